// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit, port and FSM definitions for the XY mesh
//
// Contents:
//   FLIT_HEAD/BODY/TAIL/SINGLE : 2-bit flit type codes carried in flit[MSB:MSB-1]
//   PORT_LOCAL..PORT_WEST      : bit index of each output port in a request vector
//   state_e                    : input-port FSM encoding
package noc_pkg;

  localparam logic [1:0] FLIT_HEAD   = 2'b00;
  localparam logic [1:0] FLIT_BODY   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous flit FIFO with wrap-bit pointers
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers only)
//   push_i/data_i : write request and data; ignored while full
//   pop_i         : read request; ignored while empty
//   data_o        : current head entry, combinational from storage
//   full_o/empty_o: occupancy flags
module flit_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  // The extra MSB tells a full FIFO (same index, different lap) from an empty one.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    push_en  = push_i && !full_o;
    pop_en   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/xy_input_port.sv
// rtl/xy_input_port.sv - XY mesh switch input port: buffer, route, wormhole forward
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_vld_i/in_flit_i     : upstream flit {type[1:0], payload}
//   in_rdy_o               : buffer has room
//   out_req_o              : one-hot output request (0 local,1 N,2 E,3 S,4 W)
//   out_gnt_i/out_rdy_i    : arbiter selects us / downstream accepts
//   out_vld_o/out_flit_o   : flit presented to the granted output
//   err_cnt_o/err_o        : orphan-drop counter and pulse, present only
//                            when XY_INPORT_ERR_CNT_EN is defined
module xy_input_port
  import noc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int ROUTER_X  = 1,
  parameter int ROUTER_Y  = 1,
  parameter int BUF_DEPTH = 4,
  parameter int PORT_N    = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_vld_i,
  input  logic [DATA_W+1:0] in_flit_i,
  output logic              in_rdy_o,
  output logic [PORT_N-1:0] out_req_o,
  input  logic              out_gnt_i,
  input  logic              out_rdy_i,
  output logic              out_vld_o,
  output logic [DATA_W+1:0] out_flit_o
`ifdef XY_INPORT_ERR_CNT_EN
  ,output logic [7:0]       err_cnt_o
  ,output logic             err_o
`endif
);

  localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

  logic              full, empty, push, pop;
  logic [DATA_W+1:0] head;
  logic [1:0]        head_type;
  logic [X_W-1:0]    dest_x;
  logic [Y_W-1:0]    dest_y;
  logic              is_start, is_end, xfer, orphan_drop;
  logic [PORT_N-1:0] route_sel, route_q, route_d;
  state_e            state_q, state_d;

  assign in_rdy_o = !full;
  assign push     = in_vld_i && in_rdy_o;

  flit_fifo #(.WIDTH(DATA_W+2), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (in_flit_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_type  = head[DATA_W+1:DATA_W];
  assign dest_x     = head[X_W-1:0];
  assign dest_y     = head[X_W+Y_W-1:X_W];
  assign out_flit_o = head;

  always_comb begin
    route_sel = '0;
    if (dest_x > RX)      route_sel[PORT_EAST]  = 1'b1;
    else if (dest_x < RX) route_sel[PORT_WEST]  = 1'b1;
    else if (dest_y > RY) route_sel[PORT_NORTH] = 1'b1;
    else if (dest_y < RY) route_sel[PORT_SOUTH] = 1'b1;
    else                  route_sel[PORT_LOCAL] = 1'b1;
  end

  always_comb begin
    is_start    = (head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE);
    is_end      = (head_type == FLIT_TAIL) || (head_type == FLIT_SINGLE);
    xfer        = (state_q == ST_ACTIVE) && !empty && out_gnt_i && out_rdy_i;
    // Body/tail at the front with no open packet has nowhere to go.
    orphan_drop = (state_q == ST_IDLE) && !empty && !is_start;
    pop         = xfer || orphan_drop;
    state_d     = state_q;
    route_d     = route_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty && is_start) begin
          state_d = ST_ACTIVE;
          route_d = route_sel;
        end
      end
      ST_ACTIVE: begin
        // route_q is cleared on the last pop so out_req_o drops with the state.
        if (xfer && is_end) begin
          state_d = ST_IDLE;
          route_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        route_d = '0;
      end
    endcase
  end

`ifdef XY_INPORT_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       err_q;
  assign err_cnt_o = err_cnt_q;
  assign err_o     = err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      route_q   <= '0;
`ifdef XY_INPORT_ERR_CNT_EN
      err_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      route_q   <= route_d;
`ifdef XY_INPORT_ERR_CNT_EN
      err_q     <= orphan_drop;
      if (orphan_drop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
`endif
    end
  end

  assign out_req_o = route_q;
  assign out_vld_o = (state_q == ST_ACTIVE) && !empty;

endmodule

// File: doc/xy_input_port.md
Name: xy_input_port

Overview:
- Input-side controller of one switch port in the simple XY mesh.
- Buffers incoming flits and computes the XY route from each head flit.
- Drives a one-hot request toward the output-port arbiters, then forwards the packet wormhole-style until its tail flit.
- It is the requester end of the arbiter interface: its request bits feed the arbiter `vld_input` vectors of the five output ports.

Parameters:
- DATA_W, 8, payload width per flit.
- X_W, 2, width of the destination X coordinate field.
- Y_W, 2, width of the destination Y coordinate field.
- ROUTER_X, 1, X coordinate of this router.
- ROUTER_Y, 1, Y coordinate of this router.
- BUF_DEPTH, 4, flit FIFO depth; a power of 2, at least 2.
- PORT_N, 5, number of output ports.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_vld_i  in  1  upstream flit valid.
- in_flit_i  in  DATA_W+2  upstream flit: {type[1:0], payload}.
- in_rdy_o  out  1  buffer can accept a flit.
- out_req_o  out  PORT_N  one-hot output-port request. 0=local, 1=north, 2=east, 3=south, 4=west.
- out_gnt_i  in  1  the requested output's arbiter currently selects this input.
- out_rdy_i  in  1  the downstream side of the requested output accepts a flit.
- out_vld_o  out  1  a flit is presented on out_flit_o.
- out_flit_o  out  DATA_W+2  FIFO head flit.

Behaviour:
- Flit types: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 SINGLE (a one-flit packet).
- Head/single payload layout: dest_x = payload[X_W-1:0], dest_y = payload[X_W+Y_W-1:X_W]. X_W+Y_W must not exceed DATA_W.
- FIFO behaviour:
  - in_rdy_o = !full; push when in_vld_i && in_rdy_o.
  - Push and pop in the same cycle are legal whenever not full; a full FIFO never pushes.
  - out_flit_o = FIFO head, combinational from storage.
  - Pointers use a wrap bit, so full/empty are distinguished with no occupancy loss.
- Route selection, from the head flit:
  - dest_x > ROUTER_X → east.
  - dest_x < ROUTER_X → west.
  - Otherwise dest_y > ROUTER_Y → north; dest_y < ROUTER_Y → south.
  - Otherwise → local.
  - Comparisons are unsigned.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - out_req_o = 0, out_vld_o = 0.
  - If the FIFO is non-empty and the head type is HEAD or SINGLE: latch the one-hot route into route_q and go to ACTIVE. Requests therefore start one cycle after the head reaches the FIFO front.
  - If the head type is BODY or TAIL (an orphan flit): pop it with no output and stay in IDLE.
- ACTIVE:
  - out_req_o = route_q, held constant until the packet ends.
  - out_vld_o = !empty.
  - Pop (transfer) occurs when out_vld_o && out_gnt_i && out_rdy_i.
  - Popping a TAIL or SINGLE flit returns to IDLE next cycle, with out_req_o cleared in that cycle.
  - FIFO empty mid-packet: keep the request and drop out_vld_o. Never release mid-packet.
  - out_gnt_i low: hold the flit with no pop.
  - A HEAD flit arriving mid-packet is forwarded as data, with no re-route.
- Back-to-back packets: at least one IDLE cycle separates a tail pop from the next request.
- Reset values (asynchronous, any time including mid-packet):
  - FIFO pointers = 0, state = IDLE, route_q = 0.
  - out_req_o = 0, out_vld_o = 0, in_rdy_o = 1 after reset.
  - Buffered flits are discarded.

Optional Feature:
- Macro XY_INPORT_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt_o [7:0], reset to 0.
  - Increments once per orphan flit dropped in IDLE and saturates at 8'hFF.
  - Adds output err_o, a one-cycle pulse per drop.
- When undefined: neither port exists and orphans are dropped silently.

Decomposition:
- Package noc_pkg holds:
  - flit type localparams (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE);
  - port index constants (PORT_LOCAL..PORT_WEST);
  - the FSM state encoding.
- Sub-module flit_fifo (parameters WIDTH, DEPTH) carries the synchronous FIFO with push/pop/full/empty. The top level holds the route logic and FSM.

Test Plan:
1. Router (1,1); SINGLE flit with dest (3,1), out_gnt_i=1, out_rdy_i=1 → out_req_o=5'b00100 from the 2nd cycle after push; flit popped the same cycle; out_req_o=0 the next cycle.
2. HEAD dest (1,0), BODY, TAIL; out_gnt_i low for 3 cycles → out_req_o=5'b01000 held and no pop while gnt is low; then 3 pops in 3 cycles with rdy=1; return to IDLE after TAIL.
3. Push 4 flits with rdy=0 → in_rdy_o=0 after the 4th push; 5th in_vld_i ignored; one pop restores in_rdy_o=1 the next cycle.
4. HEAD dest (1,1) then a 2-cycle gap then TAIL → out_req_o=5'b00001 stays asserted through the empty gap with out_vld_o=0; TAIL forwarded.
5. BODY flit while IDLE → dropped, out_req_o stays 0. With XY_INPORT_ERR_CNT_EN, err_cnt_o goes 0→1 and err_o pulses once; 300 orphans saturate at 8'hFF.
6. rst_ni asserted mid-packet with 2 flits buffered → out_req_o=0, out_vld_o=0 asynchronously; after release in_rdy_o=1 and FIFO empty.
